// File: rtl/memory_stage_pkg.sv
// Shared types and encodings for the MEM pipeline stage.
// Load/store funct3 codes, result-source mux encodings, FSM states and access sizing.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  // Unsigned variants only exist for loads; every unknown code falls back to a word.
  function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
    size_e sz;
    sz = SZ_W;
    case (f3)
      F3_B:  sz = SZ_B;
      F3_H:  sz = SZ_H;
      F3_BU: sz = is_store ? SZ_W : SZ_B;
      F3_HU: sz = is_store ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// Load data alignment: picks the byte/halfword lane addressed by the low
// address bits and sign- or zero-extends it to the datapath width.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_offset,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = i_rdata[{i_offset, 3'b000} +: 8];
    half_sel = i_rdata[{i_offset[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_B:    o_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_H:    o_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives a req/ack data-memory port, stalls the front of the pipe
// until ack, and registers MEM/WB. Optional trap: MEM_MISALIGN_TRAP_EN.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_alu_result_m,
  input  logic [DATA_WIDTH-1:0] i_write_data_m,
  input  logic [2:0]            i_funct3_m,
  input  logic                  i_regwrite_m,
  input  logic                  i_memwrite_m,
  input  logic [1:0]            i_resultsrc_m,
  input  logic [4:0]            i_rd_addr_m,
  input  logic [DATA_WIDTH-1:0] i_pc4_m,
  output logic [DATA_WIDTH-1:0] o_forward_m,
  output logic                  o_stall_m,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  input  logic                  i_dmem_ack,
  output logic                  o_regwrite_w,
  output logic [1:0]            o_resultsrc_w,
  output logic [4:0]            o_rd_addr_w,
  output logic [DATA_WIDTH-1:0] o_alu_result_w,
  output logic [DATA_WIDTH-1:0] o_read_data_w,
  output logic [DATA_WIDTH-1:0] o_pc4_w,
  output logic                  o_misalign_w
);

  typedef struct packed {
    logic                  regwrite;
    logic [1:0]            resultsrc;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] pc4;
    logic                  misalign;
  } wb_t;

  state_e                state_q, state_d;
  wb_t                   wb_q, wb_d;
  size_e                 sz;
  logic                  is_load, mem_op, misalign, access, ack_ok;
  logic [1:0]            offs;
  logic [DATA_WIDTH-1:0] load_data;

  assign offs        = i_alu_result_m[1:0];
  assign o_forward_m = i_alu_result_m;

  always_comb begin
    is_load = (i_resultsrc_m == RS_LOAD);
    mem_op  = is_load | i_memwrite_m;
    sz      = access_size(i_funct3_m, i_memwrite_m);
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = mem_op && (((sz == SZ_H) && offs[0]) || ((sz == SZ_W) && (offs != 2'b00)));
`else
    misalign = 1'b0;
`endif
    access = mem_op & ~misalign;
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .i_rdata  (i_dmem_rdata),
    .i_offset (offs),
    .i_funct3 (i_funct3_m),
    .o_data   (load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access)     state_d = ST_WAIT;
      ST_WAIT: if (i_dmem_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields come straight from EX/MEM, which the stall holds frozen until ack.
  // Gating with reset drops req/stall the instant reset asserts, even mid-access.
  always_comb begin
    ack_ok       = (state_q == ST_WAIT) && i_dmem_ack;
    o_dmem_req   = i_rst_n && (((state_q == ST_IDLE) && access) || (state_q == ST_WAIT));
    o_stall_m    = i_rst_n && access && !ack_ok;
    o_dmem_we    = o_dmem_req && i_memwrite_m;
    o_dmem_addr  = {i_alu_result_m[ADDR_WIDTH-1:2], 2'b00};
    o_dmem_be    = 4'b1111;
    o_dmem_wdata = i_write_data_m;
    case (sz)
      SZ_B: begin
        o_dmem_be    = 4'b0001 << offs;
        o_dmem_wdata = {(DATA_WIDTH/8){i_write_data_m[7:0]}};
      end
      SZ_H: begin
        o_dmem_be    = 4'b0011 << offs;
        o_dmem_wdata = {(DATA_WIDTH/16){i_write_data_m[15:0]}};
      end
      default: begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = i_write_data_m;
      end
    endcase
  end

  // A stalled cycle writes a bubble; a trapped access keeps its fields but never writes rd.
  always_comb begin
    wb_d = '0;
    if (!o_stall_m) begin
      wb_d.regwrite  = i_regwrite_m & ~misalign;
      wb_d.resultsrc = i_resultsrc_m;
      wb_d.rd        = i_rd_addr_m;
      wb_d.alu       = i_alu_result_m;
      wb_d.rdata     = (is_load && ack_ok) ? load_data : '0;
      wb_d.pc4       = i_pc4_m;
      wb_d.misalign  = misalign;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wb_q <= '0;
    else          wb_q <= wb_d;
  end

  assign o_regwrite_w   = wb_q.regwrite;
  assign o_resultsrc_w  = wb_q.resultsrc;
  assign o_rd_addr_w    = wb_q.rd;
  assign o_alu_result_w = wb_q.alu;
  assign o_read_data_w  = wb_q.rdata;
  assign o_pc4_w        = wb_q.pc4;
  assign o_misalign_w   = wb_q.misalign;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboarded bench for memory_stage: directed ops push expected MEM/WB
// contents; a negedge monitor pops and compares whenever MEM/WB holds a writer.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu, wdata, pc4, rdata;
  logic [2:0]  f3;
  logic        rw, mw, ack;
  logic [1:0]  rs;
  logic [4:0]  rd;

  logic [31:0] forward, dmem_wdata, alu_w, rdata_w, pc4_w;
  logic        stall, req, we, rw_w, mis_w;
  logic [7:0]  daddr;
  logic [3:0]  be;
  logic [1:0]  rs_w;
  logic [4:0]  rd_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  memory_stage dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_result_m(alu), .i_write_data_m(wdata), .i_funct3_m(f3),
    .i_regwrite_m(rw), .i_memwrite_m(mw), .i_resultsrc_m(rs),
    .i_rd_addr_m(rd), .i_pc4_m(pc4),
    .o_forward_m(forward), .o_stall_m(stall),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(daddr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_be(be),
    .i_dmem_rdata(rdata), .i_dmem_ack(ack),
    .o_regwrite_w(rw_w), .o_resultsrc_w(rs_w), .o_rd_addr_w(rd_w),
    .o_alu_result_w(alu_w), .o_read_data_w(rdata_w), .o_pc4_w(pc4_w),
    .o_misalign_w(mis_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: MEM/WB presents an instruction when it writes rd or flags a trap.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (rw_w === 1'b1 || mis_w === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {rw_w, mis_w}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_regwrite",  rw_w,    e.rw);
        chk("wb_resultsrc", rs_w,    e.rs);
        chk("wb_rd",        rd_w,    e.rd);
        chk("wb_alu",       alu_w,   e.alu);
        chk("wb_rdata",     rdata_w, e.rdata);
        chk("wb_pc4",       pc4_w,   e.pc4);
        chk("wb_misalign",  mis_w,   e.mis);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] fn,
                        input logic w, input logic m, input logic [1:0] src,
                        input logic [4:0] d, input logic [31:0] p);
    alu = a; wdata = wd; f3 = fn; rw = w; mw = m; rs = src; rd = d; pc4 = p;
  endtask

  task automatic push(input logic [31:0] rdv, input logic misv);
    exp_t e;
    e.rw = rw & ~misv; e.rs = rs; e.rd = rd; e.alu = alu;
    e.rdata = rdv; e.pc4 = pc4; e.mis = misv;
    sb.push_back(e);
  endtask

  // Single-cycle op (ALU / PC+4): no request, no stall.
  task automatic do_alu(input logic [31:0] a, input logic [1:0] src, input logic [4:0] d,
                        input logic [31:0] p);
    set_op(a, 32'h0, 3'b000, 1'b1, 1'b0, src, d, p);
    ack = 1'b0;
    push(32'h0, 1'b0);
    @(negedge clk);
    chk("alu_req", req, 1'b0);
    chk("alu_stall", stall, 1'b0);
    chk("alu_forward", forward, a);
    step();
  endtask

  // Memory op: (nwait+1) stalled cycles, then an ack cycle that releases the stall.
  task automatic do_mem(input logic store, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] fn, input logic [4:0] d, input int nwait,
                        input logic ack_idle, input logic [31:0] rv, input logic [31:0] exp_rd,
                        input logic [7:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    set_op(a, wd, fn, ~store, store, store ? 2'b00 : 2'b01, d, 32'h100);
    for (int i = 0; i <= nwait; i++) begin
      ack = (i == 0) ? ack_idle : 1'b0;
      rdata = 32'hA5A5_A5A5;
      @(negedge clk);
      chk("mem_stall", stall, 1'b1);
      chk("mem_req", req, 1'b1);
      chk("mem_addr", daddr, exp_addr);
      chk("mem_we", we, store);
      if (store) begin
        chk("st_be", be, exp_be);
        chk("st_wdata", dmem_wdata, exp_wd);
      end
      step();
    end
    ack = 1'b1;
    rdata = rv;
    if (!store) push(exp_rd, 1'b0);
    @(negedge clk);
    chk("ack_stall", stall, 1'b0);
    chk("ack_req", req, 1'b1);
    step();
    ack = 1'b0;
  endtask

  task automatic idle();
    set_op(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0);
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rdata = 32'h0;
    idle();
    @(negedge clk);
    chk("rst_req", req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rw_w", rw_w, 1'b0);
    chk("rst_alu_w", alu_w, 32'h0);
    chk("rst_mis_w", mis_w, 1'b0);
    step();
    rst_n = 1'b1;

    do_alu(32'h0000_0010, 2'b00, 5'd5, 32'h0000_0104);
    do_alu(32'h0000_0044, 2'b10, 5'd1, 32'h0000_0048);

    // Loads: LB with an ignored ack in IDLE, then the other sizes/extensions.
    do_mem(1'b0, 32'h03,  32'h0, 3'b000, 5'd7,  2, 1'b1, 32'h80FF_FF12, 32'hFFFF_FF80, 8'h00, 4'h0, 32'h0);
    do_mem(1'b0, 32'h00,  32'h0, 3'b001, 5'd8,  0, 1'b0, 32'h1234_8001, 32'hFFFF_8001, 8'h00, 4'h0, 32'h0);
    do_mem(1'b0, 32'h02,  32'h0, 3'b101, 5'd9,  1, 1'b0, 32'h80FF_FF12, 32'h0000_80FF, 8'h00, 4'h0, 32'h0);
    do_mem(1'b0, 32'h01,  32'h0, 3'b100, 5'd10, 0, 1'b0, 32'h0000_F200, 32'h0000_00F2, 8'h00, 4'h0, 32'h0);
    do_mem(1'b0, 32'h08,  32'h0, 3'b010, 5'd11, 0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h08, 4'h0, 32'h0);
    do_mem(1'b0, 32'h04,  32'h0, 3'b011, 5'd12, 0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 8'h04, 4'h0, 32'h0);

    // Stores: lane-shifted enables, replicated data, upper address bits dropped.
    do_mem(1'b1, 32'h06,  32'h0000_ABCD, 3'b001, 5'd0, 2, 1'b0, 32'h0, 32'h0, 8'h04, 4'b1100, 32'hABCD_ABCD);
    do_mem(1'b1, 32'h01,  32'h1234_5655, 3'b000, 5'd0, 0, 1'b0, 32'h0, 32'h0, 8'h00, 4'b0010, 32'h5555_5555);
    do_mem(1'b1, 32'h1F0, 32'h0BAD_F00D, 3'b010, 5'd0, 1, 1'b0, 32'h0, 32'h0, 8'hF0, 4'b1111, 32'h0BAD_F00D);
    do_mem(1'b1, 32'h08,  32'h1122_3344, 3'b100, 5'd0, 0, 1'b0, 32'h0, 32'h0, 8'h08, 4'b1111, 32'h1122_3344);

    // Reset while waiting for ack: everything drops at once, then a clean LW.
    set_op(32'h10, 32'h0, 3'b010, 1'b1, 1'b0, 2'b01, 5'd13, 32'h100);
    ack = 1'b0;
    @(negedge clk);
    chk("pre_rst_stall", stall, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_req", req, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_rw_w", rw_w, 1'b0);
    chk("midrst_rdata_w", rdata_w, 32'h0);
    step();
    rst_n = 1'b1;
    do_mem(1'b0, 32'h10, 32'h0, 3'b010, 5'd13, 0, 1'b0, 32'h1234_5678, 32'h1234_5678, 8'h10, 4'h0, 32'h0);

    // Misaligned word load.
`ifdef MEM_MISALIGN_TRAP_EN
    set_op(32'h02, 32'h0, 3'b010, 1'b1, 1'b0, 2'b01, 5'd14, 32'h100);
    ack = 1'b0;
    push(32'h0, 1'b1);
    @(negedge clk);
    chk("mis_req", req, 1'b0);
    chk("mis_stall", stall, 1'b0);
    step();
`else
    do_mem(1'b0, 32'h02, 32'h0, 3'b010, 5'd14, 0, 1'b0, 32'h89AB_CDEF, 32'h89AB_CDEF, 8'h00, 4'h0, 32'h0);
`endif

    idle();
    repeat (3) begin
      @(negedge clk);
      chk("idle_req", req, 1'b0);
      step();
    end
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
